fadd_ctrl: RTL

FADD_CTRL -- requirements
Module: fadd_ctrl

---
 rtl/fadd_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/fadd_ctrl.sv
// fadd_ctrl: issue/collect wrapper around a fixed-latency (3-edge) FP adder core.
// Operands are registered toward the core, a valid/tag shift register tracks
// in-flight ops, and results land in an 8-entry FIFO that absorbs output stalls.
// Upstream credit counts buffered plus in-flight results, so a push never hits a
// full FIFO.
// Optional feature: define FADD_CTRL_SUB_EN to honour in_sub (flip the sign of b).
module fadd_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [3:0]  in_tag,
    input  logic        in_sub,
    output logic [31:0] fa_x1,
    output logic [31:0] fa_x2,
    input  logic [31:0] fa_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic [3:0]  out_tag
);

    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] y;
    } res_t;

    logic [3:0]      vld_pipe;
    logic [3:0][3:0] tag_pipe;
    res_t            fifo_mem [8];
    logic [2:0]      wr_ptr;
    logic [2:0]      rd_ptr;
    logic [3:0]      count;
    logic            accept;
    logic            push;
    logic            pop;
    logic [2:0]      in_flight;
    logic [4:0]      credit_sum;
    logic [31:0]     x2_next;

    // Handshakes and credit; a same-cycle pop is deliberately not credited.
    always_comb begin
        in_flight  = 3'(vld_pipe[0]) + 3'(vld_pipe[1]) + 3'(vld_pipe[2]) + 3'(vld_pipe[3]);
        credit_sum = {1'b0, count} + {2'b00, in_flight};
        in_ready   = credit_sum < 5'd8;
        accept     = in_valid & in_ready;
        push       = vld_pipe[3];
        out_valid  = count != 4'd0;
        pop        = out_valid & out_ready;
    end

`ifdef FADD_CTRL_SUB_EN
    // Subtract is a sign flip on b before it reaches the core.
    assign x2_next = {in_b[31] ^ in_sub, in_b[30:0]};
`else
    logic unused_sub;
    assign unused_sub = in_sub;
    // Without the subtract option b passes through untouched.
    assign x2_next = in_b;
`endif

    // Operand registers feeding the core; hold when nothing is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fa_x1 <= '0;
            fa_x2 <= '0;
        end else if (accept) begin
            fa_x1 <= in_a;
            fa_x2 <= x2_next;
        end
    end

    // Valid/tag tracking that mirrors the core latency; stage 3 aligns with fa_y.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[2:0], accept};
            tag_pipe <= {tag_pipe[2:0], in_tag};
        end
    end

    // Result FIFO: circular buffer, pointers wrap naturally at 3 bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 8; i++) fifo_mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{tag: tag_pipe[3], y: fa_y};
                wr_ptr           <= wr_ptr + 3'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 3'd1;
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Head of the FIFO is presented directly and stays put until popped.
    always_comb begin
        out_y   = fifo_mem[rd_ptr].y;
        out_tag = fifo_mem[rd_ptr].tag;
    end

endmodule
